// File: rtl/generic_fifo_pkg.sv
// generic_fifo_pkg: shared sizing helper, constants and full-mode type for the generic FIFO family
package generic_fifo_pkg;
   localparam int c_drop_cnt_width = 16;
   typedef enum logic {FULL_BLOCK, FULL_DROP} t_full_mode;
   // Ceiling log2 with a floor of 1 bit, so a depth of 2 still gets a 1-bit pointer.
   function automatic int f_log2_size(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/generic_sync_fifo_ram.sv
// generic_sync_fifo_ram: simple dual-port inferred RAM with one write port and a registered read port
//   i_clk           clock
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr    read request; o_rdata updates only on the edge where i_re is high
module generic_sync_fifo_ram
   import generic_fifo_pkg::*;
#(
   parameter int g_width = 16,
   parameter int g_depth = 2772
)(
   input  logic                            i_clk,
   input  logic                            i_we,
   input  logic [f_log2_size(g_depth)-1:0] i_waddr,
   input  logic [g_width-1:0]              i_wdata,
   input  logic                            i_re,
   input  logic [f_log2_size(g_depth)-1:0] i_raddr,
   output logic [g_width-1:0]              o_rdata
);
   logic [g_width-1:0] r_mem [g_depth];
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/generic_sync_fifo_stream.sv
// generic_sync_fifo_stream: single-clock first-word-fall-through stream FIFO of any depth >= 2
//   clk_i, rst_n_i (async, active low), clr_i (sync flush)
//   s_d_i/s_valid_i/s_ready_o   write stream
//   m_q_o/m_valid_o/m_ready_i   read stream, head word held while stalled
//   count_o, empty_o, full_o, almost_empty_o, almost_full_o   registered occupancy
//   overflow_o, drop_cnt_o, err_clr_i   dropped-write status (drop mode only)
module generic_sync_fifo_stream
   import generic_fifo_pkg::*;
#(
   parameter int g_data_width             = 16,
   parameter int g_size                   = 2772,
   parameter int g_almost_empty_threshold = 10,
   parameter int g_almost_full_threshold  = g_size - 10,
   parameter int g_drop_on_full           = 0
)(
   input  logic                              clk_i,
   input  logic                              rst_n_i,
   input  logic                              clr_i,
   input  logic [g_data_width-1:0]           s_d_i,
   input  logic                              s_valid_i,
   output logic                              s_ready_o,
   output logic [g_data_width-1:0]           m_q_o,
   output logic                              m_valid_o,
   input  logic                              m_ready_i,
   output logic [f_log2_size(g_size+1)-1:0]  count_o,
   output logic                              empty_o,
   output logic                              full_o,
   output logic                              almost_empty_o,
   output logic                              almost_full_o,
   output logic                              overflow_o,
   output logic [c_drop_cnt_width-1:0]       drop_cnt_o,
   input  logic                              err_clr_i
);
   localparam int c_pw = f_log2_size(g_size);
   localparam int c_cw = f_log2_size(g_size + 1);
   localparam t_full_mode c_mode = (g_drop_on_full != 0) ? FULL_DROP : FULL_BLOCK;
   localparam logic [c_pw-1:0] c_last = c_pw'(g_size - 1);
   localparam logic [c_cw-1:0] c_size = c_cw'(g_size);
   localparam logic [c_cw-1:0] c_ae = c_cw'(g_almost_empty_threshold);
   localparam logic [c_cw-1:0] c_af = c_cw'(g_almost_full_threshold);
   if (g_size < 2) begin : g_chk_size
      $error("generic_sync_fifo_stream: g_size must be at least 2");
   end
   if (g_almost_empty_threshold < 0 || g_almost_empty_threshold > g_size) begin : g_chk_ae
      $error("generic_sync_fifo_stream: g_almost_empty_threshold out of range");
   end
   if (g_almost_full_threshold < 0 || g_almost_full_threshold > g_size) begin : g_chk_af
      $error("generic_sync_fifo_stream: g_almost_full_threshold out of range");
   end
   logic [c_pw-1:0] r_wr_ptr, r_rd_ptr;
   logic [c_cw-1:0] r_count, r_ram_cnt, w_count_nxt;
   logic r_rd_vld, r_valid, r_empty, r_full, r_aempty, r_afull, r_ovf;
   logic [g_data_width-1:0] r_q, w_rdata;
   logic [c_drop_cnt_width-1:0] r_drop_cnt;
   logic w_accept, w_pop, w_load, w_re, w_drop;
   // In block mode ready is the registered !full, so a pop while full only frees space next cycle.
   assign s_ready_o   = (c_mode == FULL_DROP) || !r_full;
   assign w_accept    = s_valid_i && s_ready_o && !r_full && !clr_i;
   assign w_drop      = (c_mode == FULL_DROP) && s_valid_i && r_full && !clr_i;
   assign w_pop       = r_valid && m_ready_i;
   // r_rd_vld marks a word sitting on the RAM read port; it moves to the output register when that is free.
   assign w_load      = r_rd_vld && (!r_valid || w_pop);
   // Only read when the read-port word will not be overwritten before it is consumed.
   assign w_re        = (r_ram_cnt != '0) && (!r_rd_vld || w_load);
   assign w_count_nxt = clr_i ? '0 : r_count + c_cw'(w_accept) - c_cw'(w_pop);
   generic_sync_fifo_ram #(
      .g_width (g_data_width),
      .g_depth (g_size)
   ) u_ram (
      .i_clk   (clk_i),
      .i_we    (w_accept),
      .i_waddr (r_wr_ptr),
      .i_wdata (s_d_i),
      .i_re    (w_re),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_ram_cnt  <= '0;
         r_rd_vld   <= 1'b0;
         r_valid    <= 1'b0;
         r_q        <= '0;
         r_empty    <= 1'b1;
         r_full     <= 1'b0;
         r_aempty   <= 1'b1;
         r_afull    <= 1'b0;
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_count    <= w_count_nxt;
         r_empty    <= w_count_nxt == '0;
         r_full     <= w_count_nxt == c_size;
         r_aempty   <= w_count_nxt < c_ae;
         r_afull    <= w_count_nxt > c_af;
         r_ovf      <= w_drop || (r_ovf && !err_clr_i);
         // A drop in the same cycle as err_clr_i wins and restarts the count at 1.
         r_drop_cnt <= w_drop ? (err_clr_i ? c_drop_cnt_width'(1) : r_drop_cnt + c_drop_cnt_width'(!(&r_drop_cnt)))
                              : (err_clr_i ? '0 : r_drop_cnt);
         if (clr_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
            r_rd_vld  <= 1'b0;
            r_valid   <= 1'b0;
         end else begin
            // Compare-and-reset wrap so non-power-of-two depths stay in range.
            if (w_accept) r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            if (w_re) r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            if (w_load) r_q <= w_rdata;
            r_ram_cnt <= r_ram_cnt + c_cw'(w_accept) - c_cw'(w_re);
            r_rd_vld  <= w_re || (r_rd_vld && !w_load);
            r_valid   <= w_load || (r_valid && !w_pop);
         end
      end
   end
   assign m_q_o          = r_q;
   assign m_valid_o      = r_valid;
   assign count_o        = r_count;
   assign empty_o        = r_empty;
   assign full_o         = r_full;
   assign almost_empty_o = r_aempty;
   assign almost_full_o  = r_afull;
   assign overflow_o     = r_ovf;
   assign drop_cnt_o     = r_drop_cnt;
endmodule

// File: tb/tb_generic_sync_fifo_stream.sv
// tb_generic_sync_fifo_stream: scoreboard bench running a back-pressure and a drop-mode FIFO side by side
module tb_generic_sync_fifo_stream;
   localparam int c_n  = 5;
   localparam int c_ae = 2;
   localparam int c_af = 3;
   logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0, s_valid = 1'b0, m_ready = 1'b0, err_clr = 1'b0;
   logic [7:0] s_d = 8'h00;
   logic [7:0] q [2];
   logic [2:0] cnt [2];
   logic [15:0] dcnt [2];
   logic s_ready [2], m_valid [2], empty [2], full [2], aempty [2], afull [2], ovf [2];
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   generic_sync_fifo_stream #(
      .g_data_width(8), .g_size(c_n), .g_almost_empty_threshold(c_ae),
      .g_almost_full_threshold(c_af), .g_drop_on_full(0)
   ) dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .s_d_i(s_d), .s_valid_i(s_valid),
      .s_ready_o(s_ready[0]), .m_q_o(q[0]), .m_valid_o(m_valid[0]), .m_ready_i(m_ready),
      .count_o(cnt[0]), .empty_o(empty[0]), .full_o(full[0]), .almost_empty_o(aempty[0]),
      .almost_full_o(afull[0]), .overflow_o(ovf[0]), .drop_cnt_o(dcnt[0]), .err_clr_i(err_clr)
   );
   generic_sync_fifo_stream #(
      .g_data_width(8), .g_size(c_n), .g_almost_empty_threshold(c_ae),
      .g_almost_full_threshold(c_af), .g_drop_on_full(1)
   ) dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .s_d_i(s_d), .s_valid_i(s_valid),
      .s_ready_o(s_ready[1]), .m_q_o(q[1]), .m_valid_o(m_valid[1]), .m_ready_i(m_ready),
      .count_o(cnt[1]), .empty_o(empty[1]), .full_o(full[1]), .almost_empty_o(aempty[1]),
      .almost_full_o(afull[1]), .overflow_o(ovf[1]), .drop_cnt_o(dcnt[1]), .err_clr_i(err_clr)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask
   // Reference model: a queue of accepted words stamped with their accept edge.
   // Both FIFOs accept exactly when not full; they differ only in ready and drop status.
   typedef struct {logic [7:0] d; int e;} ent_t;
   ent_t mq[$];
   int ecnt = 0, drops = 0;
   bit movf = 1'b0, mmv = 1'b0;
   always @(posedge clk or negedge rst_n) begin
      bit f;
      if (!rst_n) begin
         mq.delete();
         drops = 0;
         movf = 1'b0;
         mmv = 1'b0;
      end else begin
         ecnt++;
         f = (mq.size() == c_n);
         if (clr) mq.delete();
         else begin
            if (mmv && m_ready) void'(mq.pop_front());
            if (s_valid && !f) mq.push_back('{s_d, ecnt});
         end
         if (!clr && s_valid && f) begin
            movf = 1'b1;
            drops = err_clr ? 1 : (drops < 65535 ? drops + 1 : drops);
         end else if (err_clr) begin
            movf = 1'b0;
            drops = 0;
         end
         mmv = (mq.size() > 0) && (mq[0].e + 2 <= ecnt);
      end
   end
   // Monitor: compares every output of both FIFOs against the model, and the head word whenever one is presented.
   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("count%0d", m), 32'(cnt[m]), 32'(mq.size()));
         chk($sformatf("empty%0d", m), 32'(empty[m]), 32'(mq.size() == 0));
         chk($sformatf("full%0d", m), 32'(full[m]), 32'(mq.size() == c_n));
         chk($sformatf("almost_empty%0d", m), 32'(aempty[m]), 32'(mq.size() < c_ae));
         chk($sformatf("almost_full%0d", m), 32'(afull[m]), 32'(mq.size() > c_af));
         chk($sformatf("m_valid%0d", m), 32'(m_valid[m]), 32'(mmv));
         chk($sformatf("s_ready%0d", m), 32'(s_ready[m]), 32'(m == 1 || mq.size() != c_n));
         chk($sformatf("overflow%0d", m), 32'(ovf[m]), 32'(m == 1 && movf));
         chk($sformatf("drop_cnt%0d", m), 32'(dcnt[m]), 32'(m == 1 ? drops : 0));
         if (m_valid[m] && mmv) chk($sformatf("data%0d", m), 32'(q[m]), 32'(mq[0].d));
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic v, input logic [7:0] d, input logic r);
      s_valid = v;
      s_d = d;
      m_ready = r;
   endtask
   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1'b1, 8'h11, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      chk("fwft_count", 32'(cnt[0]), 32'd1);
      chk("fwft_empty", 32'(empty[0]), 32'd0);
      chk("fwft_valid_e0", 32'(m_valid[0]), 32'd0);
      tick();
      chk("fwft_valid_e1", 32'(m_valid[0]), 32'd0);
      tick();
      chk("fwft_valid_e2", 32'(m_valid[0]), 32'd1);
      chk("fwft_data", 32'(q[0]), 32'h11);
      drive(1'b0, 8'h00, 1'b1);
      tick();
      for (int i = 1; i <= 7; i++) begin
         drive(1'b1, 8'(i), 1'b0);
         tick();
      end
      drive(1'b0, 8'h00, 1'b0);
      chk("fill_full0", 32'(full[0]), 32'd1);
      chk("fill_ready0", 32'(s_ready[0]), 32'd0);
      chk("fill_count1", 32'(cnt[1]), 32'd5);
      chk("fill_overflow1", 32'(ovf[1]), 32'd1);
      chk("fill_drops1", 32'(dcnt[1]), 32'd2);
      drive(1'b0, 8'h00, 1'b1);
      repeat (8) tick();
      drive(1'b0, 8'h00, 1'b0);
      chk("drain_count0", 32'(cnt[0]), 32'd0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'(8'h20 + i), 1'b0);
         tick();
      end
      drive(1'b0, 8'h00, 1'b0);
      tick();
      drive(1'b1, 8'h30, 1'b1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      chk("clr_count0", 32'(cnt[0]), 32'd0);
      chk("clr_empty1", 32'(empty[1]), 32'd1);
      chk("clr_valid0", 32'(m_valid[0]), 32'd0);
      chk("clr_overflow1", 32'(ovf[1]), 32'd1);
      chk("clr_drops1", 32'(dcnt[1]), 32'd2);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("errclr_overflow1", 32'(ovf[1]), 32'd0);
      chk("errclr_drops1", 32'(dcnt[1]), 32'd0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'(8'h40 + i), 1'b0);
         tick();
      end
      drive(1'b1, 8'h4f, 1'b0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      chk("dropwins_overflow1", 32'(ovf[1]), 32'd1);
      chk("dropwins_drops1", 32'(dcnt[1]), 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'(i), 1'b0);
         tick();
      end
      drive(1'b0, 8'h00, 1'b0);
      repeat (2) tick();
      for (int i = 3; i < 23; i++) begin
         drive(1'b1, 8'(i), 1'b1);
         tick();
         chk("stream_count0", 32'(cnt[0]), 32'd3);
         chk("stream_valid0", 32'(m_valid[0]), 32'd1);
      end
      drive(1'b0, 8'h00, 1'b0);
      for (int p = 0; p < 8; p++) begin
         repeat (250) begin
            s_valid = ($urandom_range(99) < ((p % 2 == 0) ? 80 : 30));
            m_ready = ($urandom_range(99) < ((p % 2 == 0) ? 30 : 80));
            s_d = 8'($urandom);
            clr = ($urandom_range(63) == 0);
            err_clr = ($urandom_range(31) == 0);
            tick();
         end
      end
      clr = 1'b0;
      err_clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'(8'h60 + i), 1'b1);
         tick();
      end
      #3 rst_n = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("rst_count%0d", m), 32'(cnt[m]), 32'd0);
         chk($sformatf("rst_valid%0d", m), 32'(m_valid[m]), 32'd0);
         chk($sformatf("rst_q%0d", m), 32'(q[m]), 32'd0);
         chk($sformatf("rst_empty%0d", m), 32'(empty[m]), 32'd1);
         chk($sformatf("rst_aempty%0d", m), 32'(aempty[m]), 32'd1);
         chk($sformatf("rst_full%0d", m), 32'(full[m]), 32'd0);
         chk($sformatf("rst_afull%0d", m), 32'(afull[m]), 32'd0);
         chk($sformatf("rst_ready%0d", m), 32'(s_ready[m]), 32'd1);
         chk($sformatf("rst_overflow%0d", m), 32'(ovf[m]), 32'd0);
         chk($sformatf("rst_drops%0d", m), 32'(dcnt[m]), 32'd0);
      end
      drive(1'b1, 8'hEE, 1'b1);
      repeat (2) tick();
      chk("rst_ignore_count0", 32'(cnt[0]), 32'd0);
      rst_n = 1'b1;
      drive(1'b1, 8'hA5, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      chk("post_rst_count0", 32'(cnt[0]), 32'd1);
      tick();
      chk("post_rst_valid_e1", 32'(m_valid[0]), 32'd0);
      tick();
      chk("post_rst_valid_e2", 32'(m_valid[1]), 32'd1);
      chk("post_rst_data0", 32'(q[0]), 32'hA5);
      chk("post_rst_data1", 32'(q[1]), 32'hA5);
      drive(1'b0, 8'h00, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/generic_sync_fifo_stream.md
Name: generic_sync_fifo_stream

Overview:
- Single-clock, parametrised successor to the dual-clock FIFO wrapper.
- Generalises width, depth and almost-flag thresholds, and accepts any depth ≥ 2, not only powers of two.
- Adds valid/ready streaming ports on both sides, first-word-fall-through output, an optional drop-on-full mode, and sticky overflow status with a drop counter.
- Sits between streaming producers and consumers in the same clock domain, e.g. sample buffers in the RF feedback datapath.

Parameters:
- g_data_width, 16: data word width in bits.
- g_size, 2772: capacity in words. Any integer ≥ 2.
- g_almost_empty_threshold, 10: almost_empty_o is high while count < threshold.
- g_almost_full_threshold, g_size-10: almost_full_o is high while count > threshold.
- g_drop_on_full, 0: 0 = back-pressure the writer when full; 1 = always accept, and discard writes when full.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous flush.
- s_d_i  in  g_data_width  write data.
- s_valid_i  in  1  write request.
- s_ready_o  out  1  block can accept a word.
- m_q_o  out  g_data_width  head-of-FIFO data.
- m_valid_o  out  1  m_q_o holds a valid word.
- m_ready_i  in  1  consumer takes the word.
- count_o  out  $clog2(g_size+1)  words held, including the output stage.
- empty_o, full_o, almost_empty_o, almost_full_o  out  1 each  registered level flags.
- overflow_o  out  1  sticky: a write was dropped.
- drop_cnt_o  out  16  number of dropped writes; saturates at 0xFFFF.
- err_clr_i  in  1  clears overflow_o and drop_cnt_o.

Behaviour:
- Reset is asynchronous, active low, applied while rst_n_i=0. Reset values:
  - count_o=0, m_valid_o=0, m_q_o=0, full_o=0, almost_full_o=0, overflow_o=0, drop_cnt_o=0.
  - empty_o=1, almost_empty_o=1.
  - s_ready_o=1 in both modes; inputs are ignored while in reset.
- Write accept = s_valid_i & s_ready_o & !full. Pop = m_valid_o & m_ready_i.
- count_o: +1 on accept only, -1 on pop only, unchanged on both.
  - Accept and pop in the same cycle with count==g_size is not possible in mode 0, because s_ready_o is low.
  - In mode 1 that write is dropped.
  - count_o never exceeds g_size.
- s_ready_o:
  - Mode 0: registered, equal to !full for the next cycle. It has no combinational path from m_ready_i, so a pop while full frees space from the next cycle.
  - Mode 1: constant 1. A write with full=1 is discarded, sets overflow_o, and increments drop_cnt_o (saturating).
- All flags are registered and reflect the post-edge count:
  - empty = count==0.
  - full = count==g_size.
  - almost_empty = count < g_almost_empty_threshold.
  - almost_full = count > g_almost_full_threshold.
- First-word-fall-through latency:
  - A word accepted at edge N into an empty block gives m_valid_o=1 with that data after edge N+2. This is one RAM read cycle plus the output register.
  - count_o counts the word from edge N.
  - Sustained push/pop gives 1 word per cycle throughput with no bubbles once m_valid_o is high.
- m_q_o and m_valid_o are held stable while m_valid_o=1 and m_ready_i=0. The output stage must prefetch the next word so back-to-back pops are bubble-free.
- Read and write pointers wrap from g_size-1 to 0. Non-power-of-two depths must work with a compare-and-reset, not bit truncation.
- clr_i:
  - Has priority over accept and pop in the same cycle.
  - Next cycle: count=0, empty=1, m_valid_o=0, pointers=0.
  - overflow_o and drop_cnt_o are untouched.
- err_clr_i clears overflow_o and drop_cnt_o. If a drop occurs in the same cycle, the drop wins: overflow_o=1, drop_cnt_o=1.
- Reset asserted mid-operation discards all contents immediately, with no partial words. RAM contents are not reset.
- Parameter checks at elaboration: g_size ≥ 2; thresholds within 0..g_size.

Decomposition:
- Shared package generic_fifo_pkg holds:
  - function f_log2_size(n) for pointer and count widths.
  - localparam c_drop_cnt_width = 16.
  - enum t_full_mode {FULL_BLOCK, FULL_DROP}, mapped from g_drop_on_full.
- Sub-module generic_sync_fifo_ram: simple dual-port inferred RAM with synchronous read, parameters width and depth.
- Top level holds the pointers, count, flags, output prefetch register and error logic.

Test Plan (g_data_width=8, g_size=5, thresholds 2/3):
- Write 0x11 into the empty block at edge 0 -> m_valid_o=1 with m_q_o=0x11 after edge 2; count_o=1 after edge 0; empty_o=0 after edge 0.
- Mode 0: write 0x01..0x06 continuously -> full_o=1 and s_ready_o=0 at count 5; 0x06 is not accepted. Pop all -> data out is 0x01..0x05 in order, and pointers wrap correctly at depth 5.
- Mode 1: write 0x01..0x07 with m_ready_i=0 -> count_o=5, overflow_o=1, drop_cnt_o=2. Pop order is 0x01..0x05.
- Simultaneous push/pop at count 3 for 20 cycles with an incrementing pattern -> count_o stays 3, no bubbles on m_valid_o, no data lost.
- Fill to 4, then assert clr_i together with a write and a pop -> next cycle count_o=0, empty_o=1, m_valid_o=0; overflow_o is unchanged.
- Assert rst_n_i low asynchronously mid-burst -> outputs take their reset values immediately. After release, a write of 0xA5 appears after 2 edges.
